// File: rtl/fetch_pc_redirect.sv
// Fetch-stage PC register with branch/jump/exception redirect and a one-entry
// buffer that holds a redirect raised while fetch is stalled.
module fetch_pc_redirect #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic        exception,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic [31:0] id_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] index26,
    input  logic [31:0] rs_value,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush_if,
    output logic        redirect_pending
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_BGEZ    = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [5:0] FN_TEQ     = 6'b110100;

    logic [31:0] pc_q, pc_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;

    logic        is_teq, is_cbr, is_jmp, is_jreg, req;
    logic [31:0] id_pc_plus4, target;

    assign id_pc_plus4 = id_pc + 32'd4;

    always_comb begin
        is_teq  = (op == OP_SPECIAL) && (func == FN_TEQ);
        is_cbr  = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGEZ);
        is_jmp  = (op == OP_J) || (op == OP_JAL);
        is_jreg = (op == OP_SPECIAL) && ((func == FN_JR) || (func == FN_JALR));
        req     = exception | (branch & (is_teq | is_cbr | is_jmp | is_jreg));

        // Priority chain; the fall-through value is never used because req is 0 then.
        if (exception || is_teq)
            target = EXC_VECTOR;
        else if (is_cbr)
            target = id_pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
        else if (is_jmp)
            target = {id_pc_plus4[31:28], index26, 2'b00};
        else if (is_jreg)
            target = {rs_value[31:2], 2'b00};
        else
            target = pc_plus4;
    end

    always_comb begin
        pc_d       = pc_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        flush_if   = 1'b0;
        if (!stall) begin
            pend_vld_d = 1'b0;
            if (req) begin
                // A live request supersedes any buffered one.
                pc_d     = target;
                flush_if = 1'b1;
            end else if (pend_vld_q) begin
                pc_d     = pend_tgt_q;
                flush_if = 1'b1;
            end else begin
                pc_d = pc_plus4;
            end
        end else if (req) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = target;
        end
        if (rst)
            flush_if = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc               = pc_q;
    assign pc_plus4         = pc_q + 32'd4;
    assign redirect_pending = pend_vld_q;

endmodule

// File: tb/tb_fetch_pc_redirect.sv
// Bench for fetch_pc_redirect: directed vector table, hand sequences for stall
// and reset corners, and a randomized run against a behavioural model.
module tb_fetch_pc_redirect;

    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;

    logic        clk = 1'b0;
    logic        rst, stall, branch, exception;
    logic [5:0]  op, func;
    logic [31:0] id_pc, rs_value;
    logic [15:0] imm16;
    logic [25:0] index26;
    logic [31:0] pc, pc_plus4;
    logic        flush_if, redirect_pending;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_pc_redirect #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .exception(exception),
        .op(op), .func(func), .id_pc(id_pc), .imm16(imm16), .index26(index26),
        .rs_value(rs_value), .pc(pc), .pc_plus4(pc_plus4), .flush_if(flush_if),
        .redirect_pending(redirect_pending)
    );

    typedef struct {
        logic        stall, branch, exception;
        logic [5:0]  op, func;
        logic [31:0] id_pc;
        logic [15:0] imm16;
        logic [25:0] index26;
        logic [31:0] rs_value;
        logic        exp_flush;
        logic [31:0] exp_pc;
        logic        exp_pend;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; branch = 0; exception = 0; op = 6'h3f; func = 0;
        id_pc = 0; imm16 = 0; index26 = 0; rs_value = 0;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        edge_step();
        rst = 0;
    endtask

    // Reference: what the ID instruction asks for, derived from the ISA rules.
    function automatic void ref_target(input logic br, input logic exc, input logic [5:0] o,
                                       input logic [5:0] f, input logic [31:0] ipc,
                                       input logic [15:0] im, input logic [25:0] idx,
                                       input logic [31:0] rs,
                                       output logic req, output logic [31:0] tgt);
        logic [31:0] ipc4;
        ipc4 = ipc + 32'd4;
        req = 0; tgt = 0;
        if (exc) begin
            req = 1; tgt = EXC_VECTOR;
        end else if (o == 0 && f == 6'd52) begin
            req = br; tgt = EXC_VECTOR;
        end else if (o == 6'd4 || o == 6'd5 || o == 6'd1) begin
            req = br; tgt = ipc4 + 32'(int'($signed(im)) * 4);
        end else if (o == 6'd2 || o == 6'd3) begin
            req = br; tgt = (ipc4 & 32'hF000_0000) | (32'(idx) * 4);
        end else if (o == 0 && (f == 6'd8 || f == 6'd9)) begin
            req = br; tgt = rs & ~32'd3;
        end
    endfunction

    vec_t tbl[13];

    initial begin
        rst = 1;
        idle_inputs();

        //            stall br exc op     func    id_pc         imm16     index26       rs_value      fl  exp_pc        pend
        tbl[0]  = '{0, 1, 0, 6'd4,  6'd0,  32'h0040_0010, 16'hFFFC, 26'h0,        32'h0,        1, 32'h0040_0004, 0};
        tbl[1]  = '{0, 1, 0, 6'd2,  6'd0,  32'h1000_0020, 16'h0,    26'h0000100,  32'h0,        1, 32'h1000_0400, 0};
        tbl[2]  = '{0, 1, 0, 6'd0,  6'd8,  32'h0,         16'h0,    26'h0,        32'h0040_0123,1, 32'h0040_0120, 0};
        tbl[3]  = '{0, 1, 1, 6'd3,  6'd0,  32'h2000_0000, 16'h0,    26'h3FFFFFF,  32'h0,        1, 32'h0040_0004, 0};
        tbl[4]  = '{0, 1, 0, 6'd0,  6'd52, 32'h0000_1000, 16'h0,    26'h0,        32'h0,        1, 32'h0040_0004, 0};
        tbl[5]  = '{0, 1, 0, 6'h23, 6'd0,  32'h0000_1000, 16'h0,    26'h0,        32'h0,        0, 32'h0040_0004, 0};
        tbl[6]  = '{0, 1, 0, 6'd5,  6'd0,  32'h0040_0000, 16'h000F, 26'h0,        32'h0,        1, 32'h0040_0040, 0};
        tbl[7]  = '{0, 1, 0, 6'd1,  6'd0,  32'hFFFF_FFF8, 16'h0002, 26'h0,        32'h0,        1, 32'h0000_0004, 0};
        tbl[8]  = '{0, 1, 0, 6'd0,  6'd9,  32'h0,         16'h0,    26'h0,        32'hFFFF_FFFF,1, 32'hFFFF_FFFC, 0};
        tbl[9]  = '{0, 0, 1, 6'h3F, 6'd0,  32'h0,         16'h0,    26'h0,        32'h0,        1, 32'h0040_0004, 0};
        tbl[10] = '{0, 0, 0, 6'd4,  6'd0,  32'h0040_0010, 16'h0100, 26'h0,        32'h0,        0, 32'h0040_0004, 0};
        tbl[11] = '{0, 0, 0, 6'd0,  6'd8,  32'h0,         16'h0,    26'h0,        32'h1234_5678,0, 32'h0040_0004, 0};
        tbl[12] = '{1, 1, 0, 6'd4,  6'd0,  32'h0040_0010, 16'hFFFC, 26'h0,        32'h0,        0, 32'h0040_0000, 1};

        // Reset then free-running fetch.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            chk("free_pc", pc, RESET_PC + 32'(k * 4));
            chk("free_pc_plus4", pc_plus4, RESET_PC + 32'(k * 4 + 4));
            chk("free_flush", 32'(flush_if), 32'd0);
            edge_step();
        end
        chk("reset_pending", 32'(redirect_pending), 32'd0);

        for (int i = 0; i < 13; i++) begin
            do_reset();
            stall = tbl[i].stall; branch = tbl[i].branch; exception = tbl[i].exception;
            op = tbl[i].op; func = tbl[i].func; id_pc = tbl[i].id_pc; imm16 = tbl[i].imm16;
            index26 = tbl[i].index26; rs_value = tbl[i].rs_value;
            #3;
            chk($sformatf("vec%0d_flush", i), 32'(flush_if), 32'(tbl[i].exp_flush));
            edge_step();
            chk($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
            chk($sformatf("vec%0d_pend", i), 32'(redirect_pending), 32'(tbl[i].exp_pend));
        end

        // BNE held across a 3-cycle stall, released with branch low.
        do_reset();
        stall = 1; branch = 1; op = 6'd5; id_pc = 32'h0040_0000; imm16 = 16'h000F;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk("stall_flush", 32'(flush_if), 32'd0);
            edge_step();
            chk("stall_pc", pc, RESET_PC);
            chk("stall_pend", 32'(redirect_pending), 32'd1);
        end
        stall = 0; branch = 0; op = 6'h3f;
        #3;
        chk("release_flush", 32'(flush_if), 32'd1);
        edge_step();
        chk("release_pc", pc, 32'h0040_0040);
        chk("release_pend", 32'(redirect_pending), 32'd0);
        #3;
        chk("release_after_flush", 32'(flush_if), 32'd0);
        edge_step();
        chk("release_after_pc", pc, 32'h0040_0044);

        // Live request while a buffered one waits: the live one wins.
        do_reset();
        stall = 1; branch = 1; op = 6'd5; id_pc = 32'h0040_0000; imm16 = 16'h000F;
        edge_step();
        stall = 0; op = 6'd0; func = 6'd8; rs_value = 32'h0000_8001;
        edge_step();
        chk("live_wins_pc", pc, 32'h0000_8000);
        chk("live_wins_pend", 32'(redirect_pending), 32'd0);
        branch = 0; op = 6'h3f;
        edge_step();
        chk("live_wins_drop", pc, 32'h0000_8004);

        // Reset while a redirect is buffered discards it.
        do_reset();
        stall = 1; branch = 1; op = 6'd4; id_pc = 32'h0040_0010; imm16 = 16'h0100;
        edge_step();
        chk("pre_rst_pend", 32'(redirect_pending), 32'd1);
        idle_inputs();
        rst = 1;
        #3;
        chk("rst_flush", 32'(flush_if), 32'd0);
        edge_step();
        rst = 0;
        chk("rst_pc", pc, RESET_PC);
        chk("rst_pend", 32'(redirect_pending), 32'd0);
        #3;
        chk("post_rst_flush", 32'(flush_if), 32'd0);
        edge_step();
        chk("post_rst_pc", pc, RESET_PC + 32'd4);

        // Randomized run against the behavioural model.
        begin
            logic [31:0] m_pc, m_pt, tgt;
            logic        m_pv, req, exp_fl;
            logic [5:0]  ops[8];
            ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'h23, 6'h0F};
            do_reset();
            m_pc = RESET_PC; m_pv = 0; m_pt = 0;
            for (int c = 0; c < 3000; c++) begin
                rst       = ($urandom_range(0, 63) == 0);
                stall     = ($urandom_range(0, 2) == 0);
                branch    = ($urandom_range(0, 2) != 0);
                exception = ($urandom_range(0, 15) == 0);
                op        = ops[$urandom_range(0, 7)];
                case ($urandom_range(0, 3))
                    0: func = 6'd8;
                    1: func = 6'd9;
                    2: func = 6'd52;
                    default: func = 6'($urandom);
                endcase
                id_pc    = $urandom;
                imm16    = 16'($urandom);
                index26  = 26'($urandom);
                rs_value = $urandom;
                ref_target(branch, exception, op, func, id_pc, imm16, index26, rs_value, req, tgt);
                exp_fl = !rst && !stall && (req || m_pv);
                #3;
                chk("rnd_pc", pc, m_pc);
                chk("rnd_pc_plus4", pc_plus4, m_pc + 32'd4);
                chk("rnd_flush", 32'(flush_if), 32'(exp_fl));
                chk("rnd_pend", 32'(redirect_pending), 32'(m_pv));
                if (rst) begin
                    m_pc = RESET_PC; m_pv = 0;
                end else if (!stall) begin
                    if (req) m_pc = tgt;
                    else if (m_pv) m_pc = m_pt;
                    else m_pc = m_pc + 32'd4;
                    m_pv = 0;
                end else if (req) begin
                    m_pv = 1; m_pt = tgt;
                end
                edge_step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_pc_redirect.md
Name: fetch_pc_redirect

Overview:
- Fetch-stage program-counter unit. Sits directly downstream of the ID-stage branch comparer and consumes its `branch` decision.
- Computes the redirect target from the ID instruction fields and owns the PC register.
- Handles fetch stalls by buffering a redirect that arrives while stalled.
- Drives the IF/ID flush so the wrong-path fetched instruction is squashed. No delay slot.

Parameters:
- RESET_PC, 32'h0040_0000: PC value after reset.
- EXC_VECTOR, 32'h0040_0004: exception/trap handler entry address.

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- stall, input, 1: hazard stall; hold PC, do not apply a redirect.
- branch, input, 1: redirect request from the ID branch comparer.
- exception, input, 1: exception raised in ID; highest-priority redirect.
- op, input, 6: opcode of the ID instruction.
- func, input, 6: function field of the ID instruction.
- id_pc, input, 32: PC of the ID instruction.
- imm16, input, 16: ID instruction immediate.
- index26, input, 26: ID instruction jump index.
- rs_value, input, 32: forwarded rs operand, used by JR/JALR.
- pc, output, 32: current fetch PC (register).
- pc_plus4, output, 32: pc+4, combinational.
- flush_if, output, 1: squash IF/ID this cycle.
- redirect_pending, output, 1: a buffered redirect is waiting.

Behaviour:
- Reset: on the rising edge with rst=1:
  - pc <= RESET_PC.
  - Pending-redirect state cleared.
  - redirect_pending=0; flush_if=0 while rst=1.
  - Any pending redirect is discarded; this applies to reset mid-stall as well.
- Target selection, combinational, priority order:
  1. exception=1 -> EXC_VECTOR. Also forces a redirect even if branch=0.
  2. TEQ (op 000000, func 110100) with branch=1 -> EXC_VECTOR.
  3. BEQ (000100), BNE (000101), BGEZ (000001) -> id_pc + 4 + (sign_extend(imm16) << 2), mod 2^32.
  4. J (000010), JAL (000011) -> {id_pc_plus4[31:28], index26, 2'b00}, where id_pc_plus4 = id_pc + 4.
  5. JR (op 000000, func 001000), JALR (op 000000, func 001001) -> rs_value with bits [1:0] forced to 00.
  6. Any other op with branch=1 -> no redirect; the request is ignored.
- Definition: req = exception | (branch & decodable op).
- Not stalled (stall=0):
  - If req: pc <= target next edge; flush_if=1 this cycle; pending cleared.
  - Else if pending valid: pc <= pending_target; flush_if=1; pending cleared.
  - Else: pc <= pc + 4; flush_if=0.
- Stalled (stall=1):
  - pc holds; flush_if=0.
  - If req: pending_target <= target and pending valid <= 1. The last request wins; the held ID instruction re-presents the same target each cycle.
- Simultaneous req and valid pending with stall=0: the live req wins, the pending entry is dropped.
- redirect_pending equals the registered pending-valid bit.
- Latency: a redirect becomes visible on pc exactly one edge after the accepting cycle (the cycle with stall=0 and a request or valid pending).
- Arithmetic: all address adds wrap at 32 bits; no overflow flag.

Test Plan:
- Reset then 3 free-running cycles -> pc = 0x00400000, 0x00400004, 0x00400008; flush_if=0 throughout.
- BEQ taken: id_pc=0x00400010, imm16=0xFFFC, branch=1, stall=0 -> flush_if=1 that cycle; next pc=0x00400004.
- J with id_pc=0x10000020, index26=0x0000100 -> next pc=0x10000400. JR with rs_value=0x00400123 -> next pc=0x00400120.
- Stall with BNE taken (target 0x00400040) held 3 cycles, then stall drops with branch=0 -> pc frozen and redirect_pending=1 during the stall; at release flush_if=1 and next pc=0x00400040, redirect_pending=0.
- exception=1 together with a taken JAL, and TEQ branch=1 -> next pc=0x00400004 in both cases.
- Pending redirect set, then rst=1 for one cycle -> pc=0x00400000, redirect_pending=0, no later redirect.
